weight_medium: RTL and testbench
================================

// Module: weight_medium
// PURPOSE
//  Backing store for the weight register file. Serves the CPU's single-cycle read/write strobes with a one-cycle finished_out pulse.
//  Adds a host port (valid/ready) for preloading and dumping trained weights.
//  Wraps one single-port BRAM of WEIGHT_LENGTH words x W_SIZE bits. Sits directly between the cpu's weight_* ports and memory.
// PARAMETERS
//  W_SIZE        1024  bits per weight word
//  WEIGHT_LENGTH 256   number of words; A_SIZE = $clog2(WEIGHT_LENGTH)
//  READ_LATENCY  2     BRAM read latency in cycles (>=1)
// PORTS
//  clk_in              in   1       system clock, single clock domain
//  rst_in              in   1       synchronous, active-high reset
//  addr_in             in   A_SIZE  CPU word address (cpu weight_addr_out)
//  data_in             in   W_SIZE  CPU write data (cpu weight_out)
//  read_enable_in      in   1       CPU read strobe, 1-cycle pulse
//  write_enable_in     in   1       CPU write strobe, 1-cycle pulse
//  data_out            out  W_SIZE  CPU read data (cpu weight_in)
//  finished_out        out  1       1-cycle pulse: CPU op complete
//  host_addr_in        in   A_SIZE  host word address
//  host_data_in        in   W_SIZE  host write data
//  host_we_in          in   1       1 = write, 0 = read; qualified by host_valid_in
//  host_valid_in       in   1       host request valid
//  host_ready_out      out  1       request accepted when valid&ready
//  host_data_out       out  W_SIZE  host read data
//  host_data_valid_out out  1       1-cycle pulse: host read data valid
// BEHAVIOUR
//  Reset: state=IDLE, pending cleared. data_out, host_data_out = 0. finished_out, host_data_valid_out = 0.
//    host_ready_out = 0 during reset, 1 in the first IDLE cycle. BRAM contents are not cleared.
//  CPU strobe capture: any cycle with read_enable_in|write_enable_in latches {op, addr_in, data_in} into a one-entry pending slot,
//    regardless of state, so strobes are never lost. If both enables are high, the write wins and the read is dropped.
//  States: IDLE -> CPU_WR | CPU_RD | HOST_WR | HOST_RD -> (RESP) -> IDLE.
//  IDLE priority: pending CPU op, then host request. host_ready_out = 1 only in IDLE with no pending CPU op and no CPU strobe this cycle.
//  CPU write: strobe in cycle 0. BRAM written at the end of cycle 1; finished_out high in cycle 2; back to IDLE.
//  CPU read: strobe in cycle 0. Address applied in cycle 1; data_out loaded at end of cycle 1+READ_LATENCY.
//    finished_out high in cycle 2+READ_LATENCY. data_out is stable that cycle and holds until the next CPU read completes.
//  Host write: accepted in cycle 0; BRAM written at end of cycle 1. No response pulse.
//  Host read: accepted in cycle 0; host_data_out loaded and host_data_valid_out pulses in cycle 2+READ_LATENCY.
//    host_data_out then holds. data_out is never modified by host operations.
//  A CPU strobe arriving during a host op waits in the pending slot and starts on the first IDLE cycle.
//    Its finished_out is delayed by the remaining host-op cycles.
//  A second CPU strobe while one is pending or in flight is a protocol violation. It overwrites the pending slot; no error flag.
//  Address >= WEIGHT_LENGTH (non-power-of-2 depths): read returns 0, write is dropped. The finished/valid pulse still fires at normal latency.
//  Read-after-write to the same address returns the new data (the write commits before the later read issues).
//  Reset mid-operation: the in-flight op is abandoned, no finished_out or host_data_valid_out pulse, and the pending slot is cleared.
//    A BRAM write already at its commit edge may land.
//  finished_out and host_data_valid_out are each high for exactly one cycle per completed operation.
// TESTING
//  1. Reset, CPU write addr 5 = 0xA5..A5, then CPU read addr 5 -> finished_out in cycle 2, then in cycle 4 with data_out=0xA5..A5.
//  2. Host writes addr 0..3 = i+1, host reads addr 2 -> host_data_valid_out at cycle 4, host_data_out=3; data_out unchanged.
//  3. Host read accepted cycle 0, CPU read strobe cycle 1 -> host response cycle 4, finished_out cycle 8; host_ready_out 0 in cycles 1-8.
//  4. CPU read and write strobes together (addr 7, data 0x1) -> write only; a later read of 7 returns 0x1; exactly one finished pulse.
//  5. rst_in asserted in cycle 2 of a CPU read -> no finished_out; state IDLE and host_ready_out=1 in the first cycle after reset.
//  6. Back-to-back CPU reads of addr 0 and WEIGHT_LENGTH-1 -> two finished pulses, each 4 cycles after its strobe, correct data.

Source files
------------

// File: rtl/weight_medium_if.sv
// Bus bundle for weight_medium: CPU strobe port plus host valid/ready port.
// The testbench drives through the master modport; the memory wrapper takes the slave modport.
interface weight_medium_if #(
  parameter int W_SIZE = 1024,
  parameter int A_SIZE = 8
);
  logic [A_SIZE-1:0] addr_in;
  logic [W_SIZE-1:0] data_in;
  logic              read_enable_in;
  logic              write_enable_in;
  logic [W_SIZE-1:0] data_out;
  logic              finished_out;

  logic [A_SIZE-1:0] host_addr_in;
  logic [W_SIZE-1:0] host_data_in;
  logic              host_we_in;
  logic              host_valid_in;
  logic              host_ready_out;
  logic [W_SIZE-1:0] host_data_out;
  logic              host_data_valid_out;

  modport master (
    output addr_in, data_in, read_enable_in, write_enable_in,
    input  data_out, finished_out,
    output host_addr_in, host_data_in, host_we_in, host_valid_in,
    input  host_ready_out, host_data_out, host_data_valid_out
  );

  modport slave (
    input  addr_in, data_in, read_enable_in, write_enable_in,
    output data_out, finished_out,
    input  host_addr_in, host_data_in, host_we_in, host_valid_in,
    output host_ready_out, host_data_out, host_data_valid_out
  );
endinterface

// File: rtl/weight_medium.sv
// Weight memory wrapper: single-port BRAM shared between CPU strobes and a host valid/ready port.
//  state   | meaning
//  IDLE    | pending CPU op issues to BRAM here, else host request accepted
//  CPU_WR  | CPU write committed, finished_out pulse
//  CPU_RD  | waiting for BRAM read data for the CPU
//  HOST_WR | host write issued to BRAM
//  HOST_RD | host read issued on entry, then waiting for BRAM data
//  RESP    | read response pulse (finished_out or host_data_valid_out)
module weight_medium #(
  parameter  int W_SIZE        = 1024,
  parameter  int WEIGHT_LENGTH = 256,
  parameter  int READ_LATENCY  = 2,
  localparam int A_SIZE        = $clog2(WEIGHT_LENGTH)
) (
  input logic           clk_in,
  input logic           rst_in,
  weight_medium_if.slave bus
);

  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam bit FULL_DEPTH = ((1 << A_SIZE) == WEIGHT_LENGTH);

  typedef enum logic [2:0] {IDLE, CPU_WR, CPU_RD, HOST_WR, HOST_RD, RESP} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt, cnt_next;

  logic              pend_valid, pend_we;
  logic [A_SIZE-1:0] pend_addr;
  logic [W_SIZE-1:0] pend_data;

  logic              cur_host;
  logic [A_SIZE-1:0] cur_addr;
  logic [W_SIZE-1:0] cur_data;

  logic [W_SIZE-1:0] data_q, host_data_q;

  logic              strobe, host_ready, pend_take, host_take;
  logic              mem_we, addr_ok;
  logic [A_SIZE-1:0] mem_addr;
  logic [W_SIZE-1:0] mem_wdata;

  logic [W_SIZE-1:0] mem     [WEIGHT_LENGTH];
  logic [W_SIZE-1:0] rd_pipe [READ_LATENCY];

  assign strobe     = bus.read_enable_in | bus.write_enable_in;
  assign host_ready = !rst_in && (state == IDLE) && !pend_valid && !strobe;
  assign addr_ok    = FULL_DEPTH || (int'(mem_addr) < WEIGHT_LENGTH);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_we     = 1'b0;
    mem_addr   = cur_addr;
    mem_wdata  = cur_data;
    pend_take  = 1'b0;
    host_take  = 1'b0;
    case (state)
      IDLE: begin
        if (pend_valid) begin
          pend_take = 1'b1;
          mem_addr  = pend_addr;
          mem_wdata = pend_data;
          mem_we    = pend_we;
          if (pend_we) begin
            state_next = CPU_WR;
          end else begin
            state_next = CPU_RD;
            cnt_next   = CW'(READ_LATENCY - 1);
          end
        end else if (bus.host_valid_in && host_ready) begin
          host_take  = 1'b1;
          state_next = bus.host_we_in ? HOST_WR : HOST_RD;
          cnt_next   = CW'(READ_LATENCY);
        end
      end
      CPU_WR:  state_next = IDLE;
      CPU_RD, HOST_RD: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - 1'b1;
      end
      HOST_WR: begin
        mem_we     = 1'b1;
        state_next = IDLE;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_valid  <= 1'b0;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      cur_host    <= 1'b0;
      cur_addr    <= '0;
      cur_data    <= '0;
      data_q      <= '0;
      host_data_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      // A new strobe always wins over consumption so no strobe is lost.
      if (strobe) begin
        pend_valid <= 1'b1;
        pend_we    <= bus.write_enable_in;
        pend_addr  <= bus.addr_in;
        pend_data  <= bus.data_in;
      end else if (pend_take) begin
        pend_valid <= 1'b0;
      end
      if (pend_take) cur_host <= 1'b0;
      if (host_take) begin
        cur_host <= 1'b1;
        cur_addr <= bus.host_addr_in;
        cur_data <= bus.host_data_in;
      end
      if (state == CPU_RD  && cnt == '0) data_q      <= rd_pipe[READ_LATENCY-1];
      if (state == HOST_RD && cnt == '0) host_data_q <= rd_pipe[READ_LATENCY-1];
    end
  end

  // BRAM model: registered read with READ_LATENCY stages, out-of-range reads yield zero.
  always_ff @(posedge clk_in) begin
    if (mem_we && addr_ok) mem[mem_addr] <= mem_wdata;
    rd_pipe[0] <= addr_ok ? mem[mem_addr] : '0;
    for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.data_out            = data_q;
  assign bus.host_data_out       = host_data_q;
  assign bus.finished_out        = (state == CPU_WR) || (state == RESP && !cur_host);
  assign bus.host_data_valid_out = (state == RESP) && cur_host;
  assign bus.host_ready_out      = host_ready;

endmodule

// File: tb/tb_weight_medium.sv
// Scoreboard bench for weight_medium: stimulus pushes expected responses, a negedge monitor pops and checks.
module tb_weight_medium;
  localparam int W  = 1024;
  localparam int WL = 256;
  localparam int A  = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int           cyc;
    logic [W-1:0] data;
    bit           chk;
  } exp_t;

  exp_t cpu_q[$];
  exp_t host_q[$];

  weight_medium_if #(.W_SIZE(W), .A_SIZE(A)) bus ();

  weight_medium #(.W_SIZE(W), .WEIGHT_LENGTH(WL), .READ_LATENCY(2)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got(lo64)=%h expected(lo64)=%h at cycle %0d", name, act[63:0], exp[63:0], cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.finished_out === 1'b1) begin
      if (cpu_q.size() == 0) chk_val("finished_spurious", 1, 0);
      else begin
        e = cpu_q.pop_front();
        chk_val("finished_cycle", W'(cyc), W'(e.cyc));
        if (e.chk) chk_val("data_out", bus.data_out, e.data);
      end
    end
    if (bus.host_data_valid_out === 1'b1) begin
      if (host_q.size() == 0) chk_val("host_valid_spurious", 1, 0);
      else begin
        e = host_q.pop_front();
        chk_val("host_valid_cycle", W'(cyc), W'(e.cyc));
        chk_val("host_data_out", bus.host_data_out, e.data);
      end
    end
  end

  task automatic cpu_op(bit we, bit re, int addr, logic [W-1:0] data, int lat,
                        logic [W-1:0] exp_data, bit chk);
    exp_t e;
    bus.write_enable_in = we;
    bus.read_enable_in  = re;
    bus.addr_in         = A'(addr);
    bus.data_in         = data;
    e.cyc = cyc + lat; e.data = exp_data; e.chk = chk;
    cpu_q.push_back(e);
    @(posedge clk); #1;
    bus.write_enable_in = 1'b0;
    bus.read_enable_in  = 1'b0;
  endtask

  task automatic host_op(bit we, int addr, logic [W-1:0] data, logic [W-1:0] exp_data);
    exp_t e;
    bit   ok = 0;
    int   acc = 0;
    bus.host_we_in    = we;
    bus.host_addr_in  = A'(addr);
    bus.host_data_in  = data;
    bus.host_valid_in = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.host_ready_out === 1'b1) begin
        ok  = 1;
        acc = cyc;
        break;
      end
    end
    if (!ok) chk_val("host_accept_timeout", 0, 1);
    else if (!we) begin
      e.cyc = acc + 4; e.data = exp_data; e.chk = 1;
      host_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.host_valid_in = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int n = 0; n < 100; n++) begin
      if (cpu_q.size() == 0 && host_q.size() == 0) begin
        done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk_val("response_timeout", W'(done), W'(1));
    @(posedge clk); #1;
  endtask

  logic [W-1:0] pat_a5, pat_dead;

  initial begin
    pat_a5   = {128{8'hA5}};
    pat_dead = {16{64'hDEAD_BEEF_0123_4567}};
    rst = 1'b1;
    bus.addr_in = '0; bus.data_in = '0; bus.read_enable_in = 1'b0; bus.write_enable_in = 1'b0;
    bus.host_addr_in = '0; bus.host_data_in = '0; bus.host_we_in = 1'b0; bus.host_valid_in = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_val("ready_in_reset", W'(bus.host_ready_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_val("ready_after_reset", W'(bus.host_ready_out), 1);
    chk_val("data_out_reset", bus.data_out, '0);
    chk_val("host_data_out_reset", bus.host_data_out, '0);
    chk_val("finished_reset", W'(bus.finished_out), 0);
    chk_val("host_valid_reset", W'(bus.host_data_valid_out), 0);
    @(posedge clk); #1;

    // 1: CPU write then read addr 5
    cpu_op(1, 0, 5, pat_a5, 2, '0, 0);
    wait_done();
    cpu_op(0, 1, 5, '0, 4, pat_a5, 1);
    wait_done();

    // 2: host preload and read back
    for (int i = 0; i < 4; i++) host_op(1, i, W'(i + 1), '0);
    host_op(0, 2, '0, W'(3));
    wait_done();
    chk_val("data_out_untouched_by_host", bus.data_out, pat_a5);

    // 3: CPU strobe arriving during a host read
    host_op(0, 3, '0, W'(4));
    bus.read_enable_in = 1'b1;
    bus.addr_in        = A'(5);
    begin
      exp_t e;
      e.cyc = cyc + 7; e.data = pat_a5; e.chk = 1;
      cpu_q.push_back(e);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk_val($sformatf("ready_low_c%0d", k), W'(bus.host_ready_out), 0);
      @(posedge clk); #1;
      bus.read_enable_in = 1'b0;
    end
    @(negedge clk);
    chk_val("ready_back_c9", W'(bus.host_ready_out), 1);
    @(posedge clk); #1;
    wait_done();

    // 4: simultaneous read+write strobes -> write only
    cpu_op(1, 1, 7, W'(1), 2, '0, 0);
    wait_done();
    cpu_op(0, 1, 7, '0, 4, W'(1), 1);
    wait_done();

    // 5: reset in cycle 2 of a CPU read
    bus.read_enable_in = 1'b1;
    bus.addr_in        = A'(7);
    @(posedge clk); #1;
    bus.read_enable_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_val("ready_after_mid_reset", W'(bus.host_ready_out), 1);
    repeat (6) @(posedge clk);
    #1;

    // 6: back-to-back reads of first and last word
    cpu_op(1, 0, WL - 1, pat_dead, 2, '0, 0);
    wait_done();
    cpu_op(0, 1, 0, '0, 4, W'(1), 1);
    repeat (3) begin @(posedge clk); #1; end
    cpu_op(0, 1, WL - 1, '0, 4, pat_dead, 1);
    wait_done();

    chk_val("cpu_queue_empty", W'(cpu_q.size()), 0);
    chk_val("host_queue_empty", W'(host_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
